// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, FSM states,
// ALU control codes, immediate formats and decode helpers.
package riscv_mc_pkg;

  localparam logic [6:0] OPC_LW    = 7'b0000011;
  localparam logic [6:0] OPC_SW    = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_LUI    = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_type_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_type_e t);
    case (t)
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      IMM_U:   return {ir[31:12], 12'b0};
      default: return {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

  // funct7[5] selects SUB only for register-register adds; OP-IMM passes 0.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] alu_fn(input alu_op_e op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      default: return a + b;
    endcase
  endfunction

  function automatic logic is_legal(input logic [31:0] ir);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ir[14:12];
    f7 = ir[31:25];
    case (ir[6:0])
      OPC_LW, OPC_SW:   return f3 == 3'b010;
      OPC_OP:           return (f7 == 7'b0000000 && f3 inside {3'b000, 3'b010, 3'b110, 3'b111})
                            || (f7 == 7'b0100000 && f3 == 3'b000);
      OPC_OPIMM:        return f3 inside {3'b000, 3'b010, 3'b110, 3'b111};
      OPC_BR:           return f3[2:1] == 2'b00;
      OPC_JAL, OPC_LUI: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// x0 never written. With NREGS=16 the top index bit is ignored.
module riscv_mc_regfile #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  localparam int AW = (NREGS == 16) ? 4 : 5;

  logic [31:0]   regs_q [NREGS];
  logic [AW-1:0] a1, a2, aw;

  assign a1  = ra1[AW-1:0];
  assign a2  = ra2[AW-1:0];
  assign aw  = wa[AW-1:0];
  assign rd1 = regs_q[a1];
  assign rd2 = regs_q[a2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we && aw != '0) begin
      regs_q[aw] <= wd;
    end
  end

endmodule

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I core sharing one ready-handshaked memory port.
// Define RISCV_MC_TRAP_EN to trap on illegal instructions; otherwise they retire as NOPs.
module riscv_multicycle_core
  import riscv_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [3:0]  state,
  output logic        trap
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, oldpc_q, oldpc_d, ir_q, ir_d;
  logic [31:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d, mdr_q, mdr_d;

  logic [31:0] rs1_data, rs2_data, rf_wd, alu_b, alu_res, addr_sel;
  logic        rf_we;
  logic [6:0]  opcode;
  logic [2:0]  f3;

  assign opcode = ir_q[6:0];
  assign f3     = ir_q[14:12];

`ifdef RISCV_MC_TRAP_EN
  localparam state_e ILLEGAL_NEXT = S_TRAP;
  assign trap = (state_q == S_TRAP);
`else
  localparam state_e ILLEGAL_NEXT = S_FETCH;
  assign trap = 1'b0;
`endif

  riscv_mc_regfile #(.NREGS(NREGS)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (ir_q[19:15]),
    .ra2 (ir_q[24:20]),
    .rd1 (rs1_data),
    .rd2 (rs2_data),
    .we  (rf_we),
    .wa  (ir_q[11:7]),
    .wd  (rf_wd)
  );

  assign alu_b   = (state_q == S_EXECR) ? b_q : imm_gen(ir_q, IMM_I);
  assign alu_res = alu_fn(alu_decode(f3, (state_q == S_EXECR) && ir_q[30]), a_q, alu_b);

  // ALU results retire straight from EXECR/EXECI so R/I ops take 3 cycles;
  // S_ALUWB is kept only as a reserved encoding.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    oldpc_d  = oldpc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_wd    = '0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          oldpc_d = pc_q;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d      = rs1_data;
        b_d      = rs2_data;
        aluout_d = oldpc_q + imm_gen(ir_q, IMM_B);
        if (!is_legal(ir_q)) begin
          state_d = ILLEGAL_NEXT;
        end else begin
          case (opcode)
            OPC_LW, OPC_SW: state_d = S_MEMADR;
            OPC_OP:         state_d = S_EXECR;
            OPC_OPIMM:      state_d = S_EXECI;
            OPC_BR:         state_d = S_BRANCH;
            OPC_JAL:        state_d = S_JAL;
            OPC_LUI:        state_d = S_LUI;
            default:        state_d = ILLEGAL_NEXT;
          endcase
        end
      end
      S_MEMADR: begin
        aluout_d = a_q + imm_gen(ir_q, (opcode == OPC_SW) ? IMM_S : IMM_I);
        state_d  = (opcode == OPC_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we   = 1'b1;
        rf_wd   = mdr_q;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        aluout_d = alu_res;
        rf_we    = 1'b1;
        rf_wd    = alu_res;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        // funct3[0] distinguishes bne from beq
        if ((a_q == b_q) ^ f3[0]) pc_d = aluout_q;
        state_d = S_FETCH;
      end
      S_JAL: begin
        rf_we   = 1'b1;
        rf_wd   = pc_q;
        pc_d    = oldpc_q + imm_gen(ir_q, IMM_J);
        state_d = S_FETCH;
      end
      S_LUI: begin
        rf_we   = 1'b1;
        rf_wd   = imm_gen(ir_q, IMM_U);
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      oldpc_q  <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      oldpc_q  <= oldpc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
    end
  end

  // Bus outputs are forced quiet while reset is held.
  assign addr_sel  = (state_q == S_FETCH) ? pc_q : aluout_q;
  assign mem_req   = rst && (state_q inside {S_FETCH, S_MEMRD, S_MEMWR});
  assign mem_we    = rst && (state_q == S_MEMWR);
  assign mem_addr  = rst ? {addr_sel[31:2], 2'b00} : '0;
  assign mem_wdata = rst ? b_q : '0;

  assign pc    = pc_q;
  assign instr = ir_q;
  assign state = state_q;

endmodule
